decode_pipe: RTL and testbench
==============================

Name: decode_pipe

Overview:
Parametrised successor of the single-issue decode stage. Decodes one RV32I instruction per cycle, reads a write-through register file and owns the ID/EX pipeline register. Adds things the earlier stage lacks: valid tracking, load-use hazard detection with bubble insertion, downstream stall, flush, a full OP/OP_IMM ALU decode, an illegal-opcode flag and a saturating bubble counter. Sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, datapath width in bits
REG_COUNT, 32, number of architectural registers; x0 is hardwired to zero
REG_ADDR, 5, register index width; must satisfy 2**REG_ADDR >= REG_COUNT
PERF_W, 16, width of the bubble counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
validD  in  1  instrD/pcD hold a real instruction
pcD  in  XLEN  PC of the decode instruction
instrD  in  32  instruction word
stallE  in  1  execute cannot accept; hold the ID/EX register
flushE  in  1  kill the decode instruction; load a bubble into E
regWriteW  in  1  write-back enable
writeRegW  in  REG_ADDR  write-back destination
resultW  in  XLEN  write-back data
stallD  out  1  fetch and IF/ID must hold
validE, regWriteE, memWriteE, mem2regE, branchE, finishE, illegalE  out  1 each  registered controls
ALUControlE  out  4  ALU operation code
ALUSrcE  out  2  ALU operand-B select
writeRegE, rs1E, rs2E  out  REG_ADDR each  destination and sources, for forwarding
rdata1E, rdata2E, immE, pcE  out  XLEN each  registered operands
bubbleCount  out  PERF_W  count of bubbles inserted by load-use

Behaviour:
- Reset: every E output, stallD and bubbleCount are 0; all register-file entries are 0; the block is asynchronous to reset.
- Regfile: writes on the posedge when regWriteW is 1 and writeRegW is not 0; writes to x0 are ignored.
- Regfile reads are combinational. Write-through bypass: if regWriteW is 1, writeRegW is not 0 and writeRegW equals the read address, the read returns resultW. A read of x0 always returns 0.
- Source usage:
  - rs1 is used by OP, OP_IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by OP, STORE and BRANCH.
  - LUI, JAL and SYSTEM use no sources.
- Load-use hazard (loadUse) is 1 when all of the following hold:
  - validD, validE and mem2regE are 1;
  - writeRegE is not 0;
  - a used source of D equals writeRegE.
- stallD = stallE OR loadUse. This output is combinational.
- ID/EX update priority at each posedge:
  1. flushE: validE and all control outputs go to 0; data fields are don't-care.
  2. stallE: hold every E output.
  3. loadUse: insert a bubble (validE and controls to 0) and increment bubbleCount.
  4. Otherwise capture the decoded D fields. validE takes validD, and controls are gated by validD.
- bubbleCount saturates at 2**PERF_W-1. Flush bubbles are not counted.
- Main decode keeps the existing per-opcode control set.
  - Unknown opcode: illegalE is 1 and finishE is 1; all other controls are 0.
  - SYSTEM: finishE is 1.
- ALU decode:
  - LOAD, STORE and LUI use ADD with ALU_SRC_IMM.
  - JAL and JALR use ADD with ALU_SRC_PC_PLUS_4.
  - BRANCH uses ALU_SRC_RD2. func3 000/001 gives SUB, 100/101 gives SLT, 110/111 gives SLTU; 010/011 sets illegalE.
  - OP/OP_IMM func3 map: 000 ADD (SUB when OP and instr[30] is 1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA when instr[30] is 1), 110 OR, 111 AND.
  - OP uses ALU_SRC_RD2; OP_IMM uses ALU_SRC_IMM.
- Immediates:
  - I-type for OP_IMM, LOAD and JALR; S for STORE; B for BRANCH; U for LUI; J for JAL.
  - For OP_IMM shifts, the immediate is instr[24:20] zero-extended.
  - Any other opcode gives immE = 0 (no x).
- All immediates are sign-extended to XLEN as applicable.

Decomposition:
- Package cpu_pkg holds:
  - OPCODE_* constants;
  - ALU_* 4-bit codes, including the new AND/OR/XOR/SLL/SRL/SRA;
  - ALU_SRC_* 2-bit codes;
  - a packed struct ctrl_t carrying all E control bits.
- Sub-module regfile_bp is the register file with bypass. Decode and immediate logic stays inline as always_comb.

Test Plan:
- Reset mid-stream: assert reset while validE=1 -> all outputs and bubbleCount read 0 immediately; afterwards, a read of x5 returns 0.
- Bypass: regWriteW=1, writeRegW=3, resultW=0xDEAD0001, while D decodes add x4,x3,x0 -> the next cycle has rdata1E=0xDEAD0001. Then writeRegW=0 with resultW=5 -> x0 still reads 0.
- Load-use: E holds lw x7, D holds add x8,x7,x1 -> stallD=1 and validE=0 next cycle, bubbleCount=1. The following cycle the add is captured with validE=1. A D instruction of lui x8,... at the same point produces no stall.
- stallE=1 for 3 cycles with addi x1,x0,-1 in E -> E outputs stay constant and stallD=1. On release, the D instruction is captured with immE=0xFFFFFFFF.
- flushE and stallE both high -> validE=0 next cycle; bubbleCount is unchanged.
- Decode sweep: sub (instr[30]=1) gives ALU_SUB; srai x2,x2,3 gives ALU_SRA with immE=3; opcode 7'h7F gives illegalE=1, finishE=1, regWriteE=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - RV32I opcodes, ALU codes and the ID/EX control bundle
package cpu_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] ALU_SRC_RD2       = 2'd0;
  localparam logic [1:0] ALU_SRC_IMM       = 2'd1;
  localparam logic [1:0] ALU_SRC_PC_PLUS_4 = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem2reg;
    logic       branch;
    logic       finish;
    logic       illegal;
    logic [3:0] alu_control;
    logic [1:0] alu_src;
  } ctrl_t;

endpackage

// File: rtl/regfile_bp.sv
// rtl/regfile_bp.sv - Register file with x0 hardwired to zero and write-through read bypass
module regfile_bp #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_we,
  input  logic [REG_ADDR-1:0] i_waddr,
  input  logic [XLEN-1:0]     i_wdata,
  input  logic [REG_ADDR-1:0] i_raddr1,
  input  logic [REG_ADDR-1:0] i_raddr2,
  output logic [XLEN-1:0]     o_rdata1,
  output logic [XLEN-1:0]     o_rdata2
);

  localparam logic [REG_ADDR:0] LP_COUNT = (REG_ADDR+1)'(REG_COUNT);

  logic [XLEN-1:0] r_regs [REG_COUNT];
  logic            w_wr_en;
  logic            w_in1;
  logic            w_in2;

  assign w_wr_en = i_we && (i_waddr != '0) && ({1'b0, i_waddr} < LP_COUNT);
  assign w_in1   = ({1'b0, i_raddr1} < LP_COUNT);
  assign w_in2   = ({1'b0, i_raddr2} < LP_COUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // A same-cycle write is visible to the reader so decode never sees stale data.
  always_comb begin
    o_rdata1 = '0;
    if (i_raddr1 != '0 && w_in1) begin
      if (w_wr_en && i_waddr == i_raddr1) o_rdata1 = i_wdata;
      else                                o_rdata1 = r_regs[i_raddr1];
    end
  end

  always_comb begin
    o_rdata2 = '0;
    if (i_raddr2 != '0 && w_in2) begin
      if (w_wr_en && i_waddr == i_raddr2) o_rdata2 = i_wdata;
      else                                o_rdata2 = r_regs[i_raddr2];
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - RV32I decode stage with load-use bubbles, stall/flush and ID/EX register
module decode_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_ADDR  = 5,
  parameter int PERF_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validD,
  input  logic [XLEN-1:0]     pcD,
  input  logic [31:0]         instrD,
  input  logic                stallE,
  input  logic                flushE,
  input  logic                regWriteW,
  input  logic [REG_ADDR-1:0] writeRegW,
  input  logic [XLEN-1:0]     resultW,
  output logic                stallD,
  output logic                validE,
  output logic                regWriteE,
  output logic                memWriteE,
  output logic                mem2regE,
  output logic                branchE,
  output logic                finishE,
  output logic                illegalE,
  output logic [3:0]          ALUControlE,
  output logic [1:0]          ALUSrcE,
  output logic [REG_ADDR-1:0] writeRegE,
  output logic [REG_ADDR-1:0] rs1E,
  output logic [REG_ADDR-1:0] rs2E,
  output logic [XLEN-1:0]     rdata1E,
  output logic [XLEN-1:0]     rdata2E,
  output logic [XLEN-1:0]     immE,
  output logic [XLEN-1:0]     pcE,
  output logic [PERF_W-1:0]   bubbleCount
);

  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [REG_ADDR-1:0] w_rd;
  logic [REG_ADDR-1:0] w_rs1;
  logic [REG_ADDR-1:0] w_rs2;
  logic [XLEN-1:0]     w_rdata1;
  logic [XLEN-1:0]     w_rdata2;
  logic [3:0]          w_alu_op;
  ctrl_t               w_ctrl;
  logic [31:0]         w_imm32;
  logic [XLEN-1:0]     w_imm;
  logic                w_use_rs1;
  logic                w_use_rs2;
  logic                w_load_use;

  logic                r_validE;
  ctrl_t               r_ctrl;
  logic [REG_ADDR-1:0] r_writeReg;
  logic [REG_ADDR-1:0] r_rs1;
  logic [REG_ADDR-1:0] r_rs2;
  logic [XLEN-1:0]     r_rdata1;
  logic [XLEN-1:0]     r_rdata2;
  logic [XLEN-1:0]     r_imm;
  logic [XLEN-1:0]     r_pc;
  logic [PERF_W-1:0]   r_bubble;

  assign w_opcode = instrD[6:0];
  assign w_funct3 = instrD[14:12];
  assign w_rd     = REG_ADDR'(instrD[11:7]);
  assign w_rs1    = REG_ADDR'(instrD[19:15]);
  assign w_rs2    = REG_ADDR'(instrD[24:20]);

  regfile_bp #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT),
    .REG_ADDR  (REG_ADDR)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (regWriteW),
    .i_waddr  (writeRegW),
    .i_wdata  (resultW),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // instr[30] selects SUB only for register-register ops; SRA applies to both forms.
  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_op = (w_opcode == OPCODE_OP && instrD[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b011:  w_alu_op = ALU_SLTU;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = instrD[30] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      default: w_alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    w_ctrl    = '0;
    w_imm32   = '0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      OPCODE_OP: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_control = w_alu_op;
        w_ctrl.alu_src     = ALU_SRC_RD2;
        w_use_rs1          = 1'b1;
        w_use_rs2          = 1'b1;
      end
      OPCODE_OP_IMM: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_control = w_alu_op;
        w_ctrl.alu_src     = ALU_SRC_IMM;
        w_use_rs1          = 1'b1;
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) w_imm32 = {27'b0, instrD[24:20]};
        else w_imm32 = {{20{instrD[31]}}, instrD[31:20]};
      end
      OPCODE_LOAD: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem2reg   = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_IMM;
        w_use_rs1        = 1'b1;
        w_imm32          = {{20{instrD[31]}}, instrD[31:20]};
      end
      OPCODE_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_IMM;
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
        w_imm32          = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      end
      OPCODE_BRANCH: begin
        w_ctrl.branch  = 1'b1;
        w_ctrl.alu_src = ALU_SRC_RD2;
        w_use_rs1      = 1'b1;
        w_use_rs2      = 1'b1;
        w_imm32        = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
        case (w_funct3[2:1])
          2'b00:   w_ctrl.alu_control = ALU_SUB;
          2'b10:   w_ctrl.alu_control = ALU_SLT;
          2'b11:   w_ctrl.alu_control = ALU_SLTU;
          default: w_ctrl.illegal     = 1'b1;
        endcase
      end
      OPCODE_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_PC_PLUS_4;
        w_imm32          = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      end
      OPCODE_JALR: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_PC_PLUS_4;
        w_use_rs1        = 1'b1;
        w_imm32          = {{20{instrD[31]}}, instrD[31:20]};
      end
      OPCODE_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_IMM;
        w_imm32          = {instrD[31:12], 12'b0};
      end
      OPCODE_SYSTEM: w_ctrl.finish = 1'b1;
      default: begin
        w_ctrl.illegal = 1'b1;
        w_ctrl.finish  = 1'b1;
      end
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  assign w_load_use = validD && r_validE && r_ctrl.mem2reg && (r_writeReg != '0) &&
                      ((w_use_rs1 && w_rs1 == r_writeReg) || (w_use_rs2 && w_rs2 == r_writeReg));
  assign stallD     = stallE | w_load_use;

  // Data fields are left untouched on bubbles; validE and controls mark them dead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_validE   <= 1'b0;
      r_ctrl     <= '0;
      r_writeReg <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_bubble   <= '0;
    end else if (flushE) begin
      r_validE <= 1'b0;
      r_ctrl   <= '0;
    end else if (!stallE) begin
      if (w_load_use) begin
        r_validE <= 1'b0;
        r_ctrl   <= '0;
        if (r_bubble != '1) r_bubble <= r_bubble + PERF_W'(1);
      end else begin
        r_validE   <= validD;
        r_ctrl     <= validD ? w_ctrl : '0;
        r_writeReg <= w_rd;
        r_rs1      <= w_rs1;
        r_rs2      <= w_rs2;
        r_rdata1   <= w_rdata1;
        r_rdata2   <= w_rdata2;
        r_imm      <= w_imm;
        r_pc       <= pcD;
      end
    end
  end

  assign validE      = r_validE;
  assign regWriteE   = r_ctrl.reg_write;
  assign memWriteE   = r_ctrl.mem_write;
  assign mem2regE    = r_ctrl.mem2reg;
  assign branchE     = r_ctrl.branch;
  assign finishE     = r_ctrl.finish;
  assign illegalE    = r_ctrl.illegal;
  assign ALUControlE = r_ctrl.alu_control;
  assign ALUSrcE     = r_ctrl.alu_src;
  assign writeRegE   = r_writeReg;
  assign rs1E        = r_rs1;
  assign rs2E        = r_rs2;
  assign rdata1E     = r_rdata1;
  assign rdata2E     = r_rdata2;
  assign immE        = r_imm;
  assign pcE         = r_pc;
  assign bubbleCount = r_bubble;

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - Self-checking bench for decode_pipe with a reference decode model
module tb_decode_pipe;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd2, A_SLTU = 4'd3, A_AND = 4'd4;
  localparam logic [3:0] A_OR = 4'd5, A_XOR = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9;

  typedef struct packed {
    logic        rw, mw, m2r, br, fin, ill;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic [31:0] imm;
    logic        u1, u2;
  } dec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        validD, stallE, flushE, regWriteW;
  logic [31:0] pcD, instrD, resultW;
  logic [4:0]  writeRegW;
  logic        stallD, validE, regWriteE, memWriteE, mem2regE, branchE, finishE, illegalE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ALUSrcE;
  logic [4:0]  writeRegE, rs1E, rs2E;
  logic [31:0] rdata1E, rdata2E, immE, pcE;
  logic [15:0] bubbleCount;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .REG_COUNT(32), .REG_ADDR(5), .PERF_W(16)) dut (
    .clk(clk), .reset(reset), .validD(validD), .pcD(pcD), .instrD(instrD),
    .stallE(stallE), .flushE(flushE), .regWriteW(regWriteW), .writeRegW(writeRegW),
    .resultW(resultW), .stallD(stallD), .validE(validE), .regWriteE(regWriteE),
    .memWriteE(memWriteE), .mem2regE(mem2regE), .branchE(branchE), .finishE(finishE),
    .illegalE(illegalE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .writeRegE(writeRegE), .rs1E(rs1E), .rs2E(rs2E), .rdata1E(rdata1E),
    .rdata2E(rdata2E), .immE(immE), .pcE(pcE), .bubbleCount(bubbleCount)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode built from the ISA field definitions using arithmetic shifts.
  function automatic dec_t model_dec(input logic [31:0] ins);
    dec_t               d;
    logic signed [31:0] s;
    logic [31:0]        si, sb, sj;
    logic [3:0]         optab [8];
    logic [2:0]         f3;
    d     = '0;
    s     = ins;
    si    = s >>> 20;
    sb    = s >>> 19;
    sj    = s >>> 11;
    f3    = ins[14:12];
    optab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    case (ins[6:0])
      7'h33: begin
        d.rw = 1; d.u1 = 1; d.u2 = 1; d.src = 2'd0; d.alu = optab[f3];
        if (ins[30] && f3 == 3'd0) d.alu = A_SUB;
        if (ins[30] && f3 == 3'd5) d.alu = A_SRA;
      end
      7'h13: begin
        d.rw = 1; d.u1 = 1; d.src = 2'd1; d.alu = optab[f3];
        if (ins[30] && f3 == 3'd5) d.alu = A_SRA;
        d.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : si;
      end
      7'h03: begin d.rw = 1; d.m2r = 1; d.u1 = 1; d.src = 2'd1; d.imm = si; end
      7'h23: begin
        d.mw = 1; d.u1 = 1; d.u2 = 1; d.src = 2'd1;
        d.imm = (si & ~32'h1F) | 32'(ins[11:7]);
      end
      7'h63: begin
        d.br = 1; d.u1 = 1; d.u2 = 1; d.src = 2'd0;
        case (f3 >> 1)
          3'd0: d.alu = A_SUB;
          3'd1: d.ill = 1;
          3'd2: d.alu = A_SLT;
          default: d.alu = A_SLTU;
        endcase
        d.imm = (sb & ~32'hFFF) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h6F: begin
        d.rw = 1; d.src = 2'd2;
        d.imm = (sj & ~32'hFFFFF) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      7'h67: begin d.rw = 1; d.u1 = 1; d.src = 2'd2; d.imm = si; end
      7'h37: begin d.rw = 1; d.src = 2'd1; d.imm = ins & 32'hFFFFF000; end
      7'h73: d.fin = 1;
      default: begin d.ill = 1; d.fin = 1; end
    endcase
    return d;
  endfunction

  logic [31:0] m_rf [32];
  logic        m_valid;
  dec_t        m_d;
  logic [4:0]  m_wr, m_rs1, m_rs2;
  logic [31:0] m_rd1, m_rd2, m_pc;
  int          m_bc;
  dec_t        m_cur;

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (regWriteW && writeRegW == a) return resultW;
    return m_rf[a];
  endfunction

  function automatic logic model_lu();
    dec_t d;
    d = model_dec(instrD);
    return validD && m_valid && m_d.m2r && m_wr != 5'd0 &&
           ((d.u1 && instrD[19:15] == m_wr) || (d.u2 && instrD[24:20] == m_wr));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_d = '0; m_wr = '0; m_rs1 = '0; m_rs2 = '0;
      m_rd1 = '0; m_rd2 = '0; m_pc = '0; m_bc = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      m_cur = model_dec(instrD);
      if (flushE) begin
        m_valid = 0; m_d = '0;
      end else if (stallE) begin
        m_valid = m_valid;
      end else if (model_lu()) begin
        m_valid = 0; m_d = '0;
        if (m_bc < 65535) m_bc++;
      end else begin
        m_valid = validD;
        m_d     = validD ? m_cur : '0;
        m_d.imm = m_cur.imm;
        m_wr    = instrD[11:7];
        m_rs1   = instrD[19:15];
        m_rs2   = instrD[24:20];
        m_rd1   = rf_read(instrD[19:15]);
        m_rd2   = rf_read(instrD[24:20]);
        m_pc    = pcD;
      end
      if (regWriteW && writeRegW != 5'd0) m_rf[writeRegW] = resultW;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("stallD", stallD, stallE | model_lu());
      check("bubbleCount", bubbleCount, m_bc);
      check("validE", validE, m_valid);
      check("regWriteE", regWriteE, m_d.rw);
      check("memWriteE", memWriteE, m_d.mw);
      check("mem2regE", mem2regE, m_d.m2r);
      check("branchE", branchE, m_d.br);
      check("finishE", finishE, m_d.fin);
      check("illegalE", illegalE, m_d.ill);
      check("ALUControlE", ALUControlE, m_d.alu);
      check("ALUSrcE", ALUSrcE, m_d.src);
      if (m_valid) begin
        check("writeRegE", writeRegE, m_wr);
        check("rs1E", rs1E, m_rs1);
        check("rs2E", rs2E, m_rs2);
        check("rdata1E", rdata1E, m_rd1);
        check("rdata2E", rdata2E, m_rd2);
        check("immE", immE, m_d.imm);
        check("pcE", pcE, m_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    validD = v; instrD = ins; pcD = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    regWriteW = en; writeRegW = a; resultW = d;
  endtask

  logic [31:0] sweep [9];
  int          bc_before;

  initial begin
    reset = 1'b1;
    validD = 0; pcD = 0; instrD = 0; stallE = 0; flushE = 0;
    wb(0, 0, 0);
    sweep = '{32'h0F016193, 32'h00409193, 32'h0020A423, 32'hFE208EE3, 32'h008000EF,
              32'h00008067, 32'h00000073, 32'h00002063, 32'h00000017};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("lit_reset_validE", validE, 0);
    check("lit_reset_bubble", bubbleCount, 0);
    check("lit_reset_stallD", stallD, 0);
    check("lit_reset_pcE", pcE, 0);

    wb(1, 5'd1, 32'h11111111); tick();
    wb(1, 5'd2, 32'h22222222); tick();
    wb(1, 5'd5, 32'h00000055); tick();
    wb(1, 5'd7, 32'h77777777); tick();

    drive(1, 32'h00018233, 32'h100); wb(1, 5'd3, 32'hDEAD0001); tick();
    check("lit_bypass_rdata1", rdata1E, 32'hDEAD0001);
    check("lit_bypass_validE", validE, 1);
    drive(1, 32'h00000233, 32'h104); wb(1, 5'd0, 32'd5); tick();
    check("lit_x0_rdata1", rdata1E, 0);
    check("lit_x0_rdata2", rdata2E, 0);
    drive(1, 32'h00018233, 32'h108); wb(0, 0, 0); tick();
    check("lit_x3_stored", rdata1E, 32'hDEAD0001);

    drive(1, 32'h00012383, 32'h10C); tick();
    drive(1, 32'h00138433, 32'h110); #1;
    check("lit_lu_stallD", stallD, 1);
    tick();
    check("lit_lu_bubble_validE", validE, 0);
    check("lit_lu_bubbleCount", bubbleCount, 1);
    tick();
    check("lit_lu_add_validE", validE, 1);
    check("lit_lu_add_rd", writeRegE, 8);
    check("lit_lu_add_rdata2", rdata2E, 32'h11111111);
    drive(1, 32'h00012383, 32'h114); tick();
    drive(1, 32'h12345437, 32'h118); #1;
    check("lit_lui_nostall", stallD, 0);
    tick();
    check("lit_lui_imm", immE, 32'h12345000);
    check("lit_lui_bubbleCount", bubbleCount, 1);

    drive(1, 32'hFFF00093, 32'h1FC); tick();
    drive(1, 32'hFFF00493, 32'h200); stallE = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit_stall_rd", writeRegE, 1);
      check("lit_stall_pc", pcE, 32'h1FC);
      check("lit_stall_stallD", stallD, 1);
    end
    stallE = 0; tick();
    check("lit_release_rd", writeRegE, 9);
    check("lit_release_imm", immE, 32'hFFFFFFFF);

    drive(1, 32'h00012383, 32'h204); tick();
    bc_before = int'(bubbleCount);
    drive(1, 32'h00138433, 32'h208); flushE = 1; stallE = 1; tick();
    check("lit_flush_validE", validE, 0);
    check("lit_flush_bubble", bubbleCount, 16'(bc_before));
    flushE = 0; stallE = 0; tick();

    drive(1, 32'h402082B3, 32'h300); tick();
    check("lit_sub_alu", ALUControlE, A_SUB);
    drive(1, 32'h40315113, 32'h304); tick();
    check("lit_srai_alu", ALUControlE, A_SRA);
    check("lit_srai_imm", immE, 3);
    drive(1, 32'h0000007F, 32'h308); tick();
    check("lit_illegal", illegalE, 1);
    check("lit_illegal_finish", finishE, 1);
    check("lit_illegal_regwrite", regWriteE, 0);
    drive(0, 32'hFFF00093, 32'h30C); tick();
    for (int i = 0; i < 9; i++) begin
      drive(1, sweep[i], 32'h310 + 32'(4 * i));
      tick();
    end
    drive(1, 32'h00000233, 32'h400); tick();

    #2 reset = 1'b1;
    #1;
    check("lit_midreset_validE", validE, 0);
    check("lit_midreset_regwrite", regWriteE, 0);
    check("lit_midreset_pcE", pcE, 0);
    check("lit_midreset_bubble", bubbleCount, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1, 32'h00028233, 32'h500); tick();
    check("lit_x5_cleared", rdata1E, 0);
    drive(0, 0, 0); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
